// File: rtl/rgb_button_controller.sv
// rgb_button_controller: synchronizes and debounces three push-buttons, turns
// presses and held-button auto-repeats into requests, and round-robin arbitrates
// them onto one shared increment path owning the three colour values.
module rgb_button_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_RATE     = 16,
    parameter int unsigned VAL_W           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_red,
    input  logic             btn_green,
    input  logic             btn_blue,
    output logic [VAL_W-1:0] val_red,
    output logic [VAL_W-1:0] val_green,
    output logic [VAL_W-1:0] val_blue,
    output logic [2:0]       inc_pulse,
    output logic [2:0]       btn_state
);

    localparam int unsigned NCH  = 3;
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RP_W = $clog2(REPEAT_DELAY + 1);

    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       state_d;
    logic [2:0]       pending;
    logic [2:0]       press_req;
    logic [2:0]       rep_req;
    logic [2:0]       req;
    logic [2:0]       grant;
    logic [1:0]       rr_ptr;
    logic [1:0]       rr_next;
    logic [DB_W-1:0]  db_cnt [NCH];
    logic [RP_W-1:0]  rp_cnt [NCH];
    logic [VAL_W-1:0] val_q  [NCH];

    assign raw       = {btn_blue, btn_green, btn_red};
    assign val_red   = val_q[0];
    assign val_green = val_q[1];
    assign val_blue  = val_q[2];

    // Two-flop synchronizer per raw button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_state <= '0;
            state_d   <= '0;
            for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
        end else begin
            state_d <= btn_state;
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] != btn_state[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        btn_state[i] <= ~btn_state[i];
                        db_cnt[i]    <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Request sources: press on accepted rising edge, repeat when the hold timer expires.
    always_comb begin
        press_req = btn_state & ~state_d;
        rep_req   = '0;
        for (int i = 0; i < NCH; i++) begin
            rep_req[i] = btn_state[i] && (rp_cnt[i] == RP_W'(REPEAT_DELAY - 1));
        end
        req = press_req | rep_req;
    end

    // Hold timer: counts from acceptance, reloads so later repeats are REPEAT_RATE apart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) rp_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!btn_state[i]) begin
                    rp_cnt[i] <= '0;
                end else if (rep_req[i]) begin
                    rp_cnt[i] <= RP_W'(REPEAT_DELAY - REPEAT_RATE);
                end else begin
                    rp_cnt[i] <= rp_cnt[i] + RP_W'(1);
                end
            end
        end
    end

    // Round-robin pick: first pending channel at or after the pointer.
    always_comb begin
        grant = '0;
        case (rr_ptr)
            2'd0: begin
                if      (pending[0]) grant = 3'b001;
                else if (pending[1]) grant = 3'b010;
                else if (pending[2]) grant = 3'b100;
            end
            2'd1: begin
                if      (pending[1]) grant = 3'b010;
                else if (pending[2]) grant = 3'b100;
                else if (pending[0]) grant = 3'b001;
            end
            default: begin
                if      (pending[2]) grant = 3'b100;
                else if (pending[0]) grant = 3'b001;
                else if (pending[1]) grant = 3'b010;
            end
        endcase
        rr_next = rr_ptr;
        if (grant[0]) rr_next = 2'd1;
        if (grant[1]) rr_next = 2'd2;
        if (grant[2]) rr_next = 2'd0;
    end

    // Shared increment path; a new request on the granted channel overrides its clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            inc_pulse <= '0;
            rr_ptr    <= 2'd0;
            for (int i = 0; i < NCH; i++) val_q[i] <= '0;
        end else begin
            pending   <= (pending & ~grant) | req;
            inc_pulse <= grant;
            rr_ptr    <= rr_next;
            for (int i = 0; i < NCH; i++) begin
                if (grant[i]) val_q[i] <= val_q[i] + VAL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rgb_button_controller.sv
// Scoreboard bench for rgb_button_controller: stimulus tasks push the expected
// increment events (cycle, strobe, all three values); a negedge monitor pops them.
module tb_rgb_button_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_red = 1'b0;
    logic       btn_green = 1'b0;
    logic       btn_blue = 1'b0;
    logic [3:0] val_red;
    logic [3:0] val_green;
    logic [3:0] val_blue;
    logic [2:0] inc_pulse;
    logic [2:0] btn_state;

    rgb_button_controller #(
        .DEBOUNCE_CYCLES(16),
        .REPEAT_DELAY   (64),
        .REPEAT_RATE    (16),
        .VAL_W          (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_red   (btn_red),
        .btn_green (btn_green),
        .btn_blue  (btn_blue),
        .val_red   (val_red),
        .val_green (val_green),
        .val_blue  (val_blue),
        .inc_pulse (inc_pulse),
        .btn_state (btn_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned t;
        logic [2:0]  p;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } ev_t;

    ev_t         exp_q[$];
    logic [3:0]  m_val [3];
    int unsigned cyc = 0;
    int unsigned green_high = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Edge counter: value seen at a negedge equals the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (reset && btn_state[1]) green_high <= green_high + 1;
        if (reset && inc_pulse != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(inc_pulse), 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.t);
                check("pulse_onehot", 32'(inc_pulse), 32'(e.p));
                check("val_red", 32'(val_red), 32'(e.r));
                check("val_green", 32'(val_green), 32'(e.g));
                check("val_blue", 32'(val_blue), 32'(e.b));
            end
        end
    end

    task automatic model_push(input int ch, input int unsigned t);
        ev_t e;
        m_val[ch] = m_val[ch] + 4'd1;
        e.t = t;
        e.p = 3'(1 << ch);
        e.r = m_val[0];
        e.g = m_val[1];
        e.b = m_val[2];
        exp_q.push_back(e);
    endtask

    // Expected events for buttons in mask rising together at edge c+1 and held h samples.
    task automatic push_press(input logic [2:0] mask, input int unsigned h, input int unsigned c);
        int idx;
        idx = 0;
        for (int ch = 0; ch < 3; ch++) begin
            if (mask[ch]) begin
                model_push(ch, c + 20 + idx);
                idx++;
            end
        end
        for (int unsigned k = 64; k <= h; k += 16) begin
            idx = 0;
            for (int ch = 0; ch < 3; ch++) begin
                if (mask[ch]) begin
                    model_push(ch, c + 19 + k + idx);
                    idx++;
                end
            end
        end
    endtask

    task automatic set_btns(input logic [2:0] mask, input logic v);
        if (mask[0]) btn_red   = v;
        if (mask[1]) btn_green = v;
        if (mask[2]) btn_blue  = v;
    endtask

    task automatic drive_press(input logic [2:0] mask, input int unsigned h, input int unsigned gap);
        @(negedge clk);
        push_press(mask, h, cyc);
        set_btns(mask, 1'b1);
        repeat (h) @(negedge clk);
        set_btns(mask, 1'b0);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_val_red"}, 32'(val_red), 0);
        check({tag, "_val_green"}, 32'(val_green), 0);
        check({tag, "_val_blue"}, 32'(val_blue), 0);
        check({tag, "_inc_pulse"}, 32'(inc_pulse), 0);
        check({tag, "_btn_state"}, 32'(btn_state), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        reset = 1'b0;
        set_btns(3'b111, 1'b0);
        for (int i = 0; i < 3; i++) m_val[i] = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned c;
        int unsigned g0;
        for (int i = 0; i < 3; i++) m_val[i] = 4'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Clean red press: single increment 20 edges after first high sample, no repeat.
        drive_press(3'b001, 40, 40);
        check("t1_val_red", 32'(val_red), 1);

        // Bouncing green never accepted.
        do_reset();
        g0 = green_high;
        for (int i = 0; i < 10; i++) begin
            btn_green = 1'b1;
            repeat (5) @(negedge clk);
            btn_green = 1'b0;
            repeat (5) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        check("t2_green_state_rose", green_high - g0, 0);
        check("t2_val_green", 32'(val_green), 0);

        // Simultaneous presses: red, green, blue on consecutive cycles, twice.
        do_reset();
        drive_press(3'b111, 40, 40);
        drive_press(3'b111, 40, 40);
        check("t3_val_red", 32'(val_red), 2);
        check("t3_val_green", 32'(val_green), 2);
        check("t3_val_blue", 32'(val_blue), 2);

        // Blue held: press plus repeats at held cycles 64..176.
        do_reset();
        drive_press(3'b100, 180, 40);
        check("t4_val_blue", 32'(val_blue), 9);

        // Sixteen red presses wrap 15 -> 0.
        do_reset();
        for (int i = 0; i < 16; i++) drive_press(3'b001, 20, 40);
        check("t5_val_red_wrap", 32'(val_red), 0);

        // Reset mid-debounce, then re-acceptance while still held.
        do_reset();
        @(negedge clk);
        btn_red = 1'b1;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("t6_async");
        @(negedge clk);
        reset = 1'b1;
        c = cyc;
        model_push(0, c + 20);
        repeat (40) @(negedge clk);
        btn_red = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_val_red", 32'(val_red), 1);

        // Reset during auto-repeat, then one new increment after full debounce.
        do_reset();
        @(negedge clk);
        c = cyc;
        btn_blue = 1'b1;
        model_push(2, c + 20);
        model_push(2, c + 83);
        repeat (90) @(negedge clk);
        check("t7_events_before_reset", exp_q.size(), 0);
        #2 reset = 1'b0;
        #1 check_all_zero("t7_async");
        for (int i = 0; i < 3; i++) m_val[i] = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        c = cyc;
        model_push(2, c + 20);
        repeat (40) @(negedge clk);
        btn_blue = 1'b0;
        repeat (40) @(negedge clk);
        check("t7_val_blue", 32'(val_blue), 1);
        check("final_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
